// File: rtl/iter_shifter.sv
// Iterative barrel shifter: one power-of-two stage per cycle, MSB stage first.
// Supports SLL, SRL, SRA and ROL behind a start/ready handshake.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_mode,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_SLL = 2'd0,
        MODE_SRL = 2'd1,
        MODE_SRA = 2'd2,
        MODE_ROL = 2'd3
    } mode_e;

    state_e             state;
    state_e             next_state;
    mode_e              mode_q;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] shamt_q;
    logic [SHAMT_W-1:0] cnt;

    logic [SHAMT_W:0]   stage_amt;
    logic [SHAMT_W:0]   rot_amt;
    logic               stage_en;
    logic [WIDTH-1:0]   stage_out;
    logic [WIDTH-1:0]   stage_next;
    logic               accept;

    // Start is honoured only when no operation is in flight.
    assign accept = ctrl_start && ((state == IDLE) || (state == DONE));

    always_comb begin
        stage_amt  = (SHAMT_W+1)'(1) << cnt;
        rot_amt    = (SHAMT_W+1)'(WIDTH) - stage_amt;
        stage_en   = |(shamt_q & (SHAMT_W'(1) << cnt));
        stage_out  = acc;
        case (mode_q)
            MODE_SLL: stage_out = acc << stage_amt;
            MODE_SRL: stage_out = acc >> stage_amt;
            MODE_SRA: stage_out = $signed(acc) >>> stage_amt;
            MODE_ROL: stage_out = (acc << stage_amt) | (acc >> rot_amt);
            default:  stage_out = acc;
        endcase
        stage_next = stage_en ? stage_out : acc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ctrl_start) next_state = SHIFT;
            SHIFT:   if (cnt == '0) next_state = DONE;
            DONE:    next_state = ctrl_start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    data_resultRDY = 1'b1;
            default: ;
        endcase
    end

    // The final stage result is written straight into data_result so it is
    // already valid in the DONE cycle and held until the next DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc         <= '0;
            shamt_q     <= '0;
            mode_q      <= MODE_SLL;
            cnt         <= '0;
            data_result <= '0;
        end else if (accept) begin
            acc     <= data_operandA;
            shamt_q <= ctrl_shiftamt;
            mode_q  <= mode_e'(ctrl_mode);
            cnt     <= SHAMT_W'(SHAMT_W - 1);
        end else if (state == SHIFT) begin
            acc <= stage_next;
            if (cnt == '0) begin
                data_result <= stage_next;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: hand-computed results, latency and
// handshake checks, mid-operation start and reset behaviour.
module tb_iter_shifter;

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic [1:0]  ctrl_mode;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    iter_shifter #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_mode      (ctrl_mode),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Entered 1 time unit after an edge with the DUT in IDLE or DONE.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                          input logic [4:0] s, input logic [31:0] exp);
        int cyc;
        int busy_cnt;
        ctrl_start    = 1'b1;
        ctrl_mode     = m;
        data_operandA = a;
        ctrl_shiftamt = s;
        step();
        ctrl_start = 1'b0;
        cyc        = 1;
        busy_cnt   = 0;
        while (!data_resultRDY && cyc < 20) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 6);
        check({tag, "_busycycles"}, busy_cnt, 5);
        check({tag, "_result"}, data_result, exp);
        step();
        check({tag, "_rdy_single"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int cyc;
        int rdy_seen;
        reset         = 1'b1;
        ctrl_start    = 1'b0;
        ctrl_mode     = 2'b00;
        data_operandA = '0;
        ctrl_shiftamt = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_result", data_result, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        step();

        run_op("sll_1_by4",      2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010);
        run_op("sra_msb_by31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("srl_msb_by31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_op("sra_pos_by4",    2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF);
        run_op("rol_by1",        2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003);
        run_op("rol_by16",       2'b11, 32'h1234_5678, 5'd16, 32'h5678_1234);
        run_op("srl_by8",        2'b01, 32'hDEAD_BEEF, 5'd8,  32'h00DE_ADBE);
        run_op("sra_by8",        2'b10, 32'hDEAD_BEEF, 5'd8,  32'hFFDE_ADBE);
        run_op("sll_by31",       2'b00, 32'hF000_000F, 5'd31, 32'h8000_0000);
        run_op("rol_by31",       2'b11, 32'h8000_0000, 5'd31, 32'h4000_0000);
        run_op("sll_zero",       2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op("srl_zero",       2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op("sra_zero",       2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op("rol_zero",       2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

        // Start while busy must be ignored.
        ctrl_start    = 1'b1;
        ctrl_mode     = 2'b01;
        data_operandA = 32'hF000_0000;
        ctrl_shiftamt = 5'd4;
        step();
        ctrl_start = 1'b0;
        step();
        ctrl_start    = 1'b1;
        ctrl_mode     = 2'b00;
        data_operandA = 32'h0000_0001;
        ctrl_shiftamt = 5'd1;
        step();
        ctrl_start = 1'b0;
        check("busy_start_hold", data_result, 32'hDEAD_BEEF);
        cyc = 3;
        while (!data_resultRDY && cyc < 20) begin
            step();
            cyc++;
        end
        check("busy_start_latency", cyc, 6);
        check("busy_start_result", data_result, 32'h0F00_0000);

        // Back-to-back start on the RDY cycle.
        ctrl_start    = 1'b1;
        ctrl_mode     = 2'b11;
        data_operandA = 32'h0000_ABCD;
        ctrl_shiftamt = 5'd8;
        step();
        ctrl_start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!data_resultRDY && cyc < 20) begin
            check("b2b_hold", data_result, 32'h0F00_0000);
            step();
            cyc++;
        end
        check("b2b_latency", cyc, 6);
        check("b2b_result", data_result, 32'h00AB_CD00);
        step();

        // Reset in the third SHIFT cycle discards the operation.
        ctrl_start    = 1'b1;
        ctrl_mode     = 2'b00;
        data_operandA = 32'h0000_0003;
        ctrl_shiftamt = 5'd2;
        step();
        ctrl_start = 1'b0;
        step();
        step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_result", data_result, 32'h0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_resultRDY) rdy_seen++;
            step();
        end
        check("midreset_no_rdy", rdy_seen, 0);
        run_op("post_reset_sll", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
